gray_conv_scheduler: RTL and testbench
======================================

Name: gray_conv_scheduler

Overview:
Shares one binary/Gray conversion engine between two requesters. The engine supports both directions:
- binary->Gray: 1-cycle datapath.
- Gray->binary: bit-serial, MSB-first, WIDTH cycles.
A round-robin arbiter grants the engine to one requester. A valid/ready handshake on each request port and on the result port sequences each conversion. The block sits between the converter datapath and the units that need code conversion.

Parameters:
WIDTH, 4, data width in bits of every data port; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has a request
req0_mode  input  1  0 = binary->Gray, 1 = Gray->binary
req0_data  input  WIDTH  operand from requester 0
req0_ready  output  1  requester 0 request accepted this cycle when high together with req0_valid
req1_valid  input  1  requester 1 has a request
req1_mode  input  1  same encoding as req0_mode
req1_data  input  WIDTH  operand from requester 1
req1_ready  output  1  requester 1 accept strobe, same rule as req0_ready
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  WIDTH  converted value
res_id  output  1  requester that owns res_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high. While rst=1 at a clock edge:
  - state <= IDLE.
  - res_valid, res_data, res_id <= 0.
  - last_gnt <= 1, so req0 wins the first tie.
  - An in-flight conversion is discarded and never reported.
- FSM states: IDLE, B2G, G2B, DONE.
- IDLE, grant selection:
  - Only req0 valid: grant = 0.
  - Only req1 valid: grant = 1.
  - Both valid: grant = !last_gnt.
- IDLE, ready outputs:
  - reqN_ready = (state==IDLE) && (grant==N), purely combinational.
  - Both ready outputs are 0 in every other state.
- IDLE, accept (valid&&ready):
  - Capture operand, mode and id; last_gnt <= grant.
  - Next state is B2G when mode=0, G2B when mode=1.
- B2G: res_data <= op ^ (op >> 1), then go to DONE.
  - res_valid rises exactly 2 edges after the accept edge.
- G2B: bit counter i runs WIDTH-1 down to 0, one bit per cycle.
  - res[WIDTH-1] = op[WIDTH-1].
  - res[i] = res[i+1] ^ op[i] for lower bits.
  - After bit 0, go to DONE.
  - res_valid rises exactly WIDTH+1 edges after the accept edge.
  - res_data may show partial values during G2B; they are not valid.
- DONE: res_valid=1; res_data and res_id are held stable until res_ready=1.
  - On res_valid && res_ready, go to IDLE and drop res_valid.
  - res_data and res_id keep their last value after that.
  - The earliest next accept is the cycle after returning to IDLE; there is no accept/complete overlap.
- Requests:
  - Requesters keep valid, mode and data stable until ready.
  - A deasserted valid withdraws the request with no side effects.
  - The non-granted requester is stalled with no data loss; it wins the next arbitration if it is still valid.
- busy = (state != IDLE).

Optional Feature:
- Macro: GRAY_CONV_PARITY_EN.
- When defined:
  - Adds output port res_parity (1 bit) = XOR-reduction of res_data.
  - Registered together with res_data; valid only when res_valid=1.
  - Reset value 0.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=4, after reset, req0 valid mode=0 data=8 -> req0_ready=1 same cycle; res_valid 2 edges later with res_data=4'hC, res_id=0.
- req1 valid mode=1 data=4'hB -> res_valid 5 edges after accept; res_data=4'hD (13), res_id=1.
- Both requesters valid in the first cycle after reset (req0 mode=0 data=15, req1 mode=0 data=0), res_ready=1 -> req0 served first with res_data=4'h8; req1 served next with res_data=0.
- res_ready held low 3 cycles in DONE -> res_valid, res_data and res_id stable; both req*_ready=0 and busy=1; completes on the res_ready edge, then returns to IDLE.
- rst asserted during G2B (second bit cycle) -> next edge: state IDLE, res_valid=0, busy=0; a following req1 request is granted first-in-tie to req0 per last_gnt=1.
- With GRAY_CONV_PARITY_EN defined: b=13 binary->Gray -> res_data=4'hB, res_parity=1; b=8 -> res_data=4'hC, res_parity=0.

Source files
------------

// File: rtl/gray_conv_scheduler.sv
// gray_conv_scheduler: one binary/Gray conversion engine shared by two
// requesters through a round-robin arbiter.
//   binary->Gray : single datapath cycle (state B2G)
//   Gray->binary : bit-serial, MSB first, WIDTH cycles (state G2B)
// Optional feature macro: GRAY_CONV_PARITY_EN adds res_parity, the
// XOR-reduction of res_data, registered alongside it.
//
// Handshake rule (all ports): a transfer happens on a rising edge where
// valid and ready are both high. Requesters hold valid/mode/data stable
// until ready; dropping valid before that withdraws the request. The
// consumer sees res_data/res_id stable while res_valid is high, until it
// raises res_ready.
module gray_conv_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef GRAY_CONV_PARITY_EN
  output logic             res_parity,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B2G  = 2'd1,
    G2B  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             last_gnt;
  logic             grant;
  logic             accept;
  logic             acc_mode;
  logic [WIDTH-1:0] acc_data;
  logic [WIDTH-1:0] op;
  logic [CW-1:0]    bit_cnt;
  logic             g2b_prev;
  logic             g2b_bit;

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  assign grant    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
  assign acc_mode = grant ? req1_mode : req0_mode;
  assign acc_data = grant ? req1_data : req0_data;
  assign accept   = (state == IDLE) && (grant ? req1_valid : req0_valid);
  assign busy     = (state != IDLE);

  // Current Gray->binary output bit: running XOR of the Gray bits seen so far.
  assign g2b_bit  = g2b_prev ^ op[bit_cnt];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and ready decode; ready is offered only in IDLE.
  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = ~grant;
        req1_ready = grant;
        if (accept) next_state = acc_mode ? G2B : B2G;
      end
      B2G:  next_state = DONE;
      G2B:  if (bit_cnt == '0) next_state = DONE;
      DONE: if (res_valid && res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, the two conversion engines and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      last_gnt  <= 1'b1;
      op        <= '0;
      bit_cnt   <= '0;
      g2b_prev  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op       <= acc_data;
            res_id   <= grant;
            last_gnt <= grant;
            bit_cnt  <= CW'(WIDTH - 1);
            g2b_prev <= 1'b0;
          end
        end
        B2G: res_data <= op ^ (op >> 1);
        G2B: begin
          res_data[bit_cnt] <= g2b_bit;
          g2b_prev          <= g2b_bit;
          if (bit_cnt != '0) bit_cnt <= bit_cnt - CW'(1);
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!res_valid)     res_valid <= 1'b1;
          else if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_CONV_PARITY_EN
  // Parity is registered on the same edge that raises res_valid.
  always_ff @(posedge clk) begin
    if (rst)                          res_parity <= 1'b0;
    else if (state == DONE && !res_valid) res_parity <= ^res_data;
  end
`endif

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Directed testbench for gray_conv_scheduler (WIDTH=4).
module tb_gray_conv_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_mode, req0_ready;
  logic [W-1:0] req0_data;
  logic         req1_valid, req1_mode, req1_ready;
  logic [W-1:0] req1_data;
  logic         res_valid, res_ready, res_id, busy;
  logic [W-1:0] res_data;
`ifdef GRAY_CONV_PARITY_EN
  logic         res_parity;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat;

  gray_conv_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
`ifdef GRAY_CONV_PARITY_EN
    .res_parity(res_parity),
`endif
    .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic m, input logic [W-1:0] d);
    if (n == 0) begin req0_valid = v; req0_mode = m; req0_data = d; end
    else        begin req1_valid = v; req1_mode = m; req1_data = d; end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Called right after the accept edge; returns edges from accept to res_valid, -1 on timeout.
  task automatic wait_result(output int l);
    l = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (res_valid === 1'b1) begin
        l = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    res_ready = 1'b0;
    tick();
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_vec++; if (res_data !== 4'h0) begin n_err++; $display("FAIL reset_res_data: got %h required 0", res_data); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL reset_res_id: got %b required 0", res_id); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_b2g();
    set_req(0, 1'b1, 1'b0, 4'h8);
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL b2g_req0_ready: got %b required 1", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL b2g_req1_ready: got %b required 0", req1_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2g_busy: got %b required 1", busy); end
    wait_result(lat);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL b2g_latency: got %0d required 2", lat); end
    n_vec++; if (res_data !== 4'hC) begin n_err++; $display("FAIL b2g_data: got %h required c", res_data); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL b2g_id: got %b required 0", res_id); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2g_done_valid: got %b required 0", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2g_done_busy: got %b required 0", busy); end
    n_vec++; if (res_data !== 4'hC) begin n_err++; $display("FAIL b2g_data_kept: got %h required c", res_data); end
  endtask

  task automatic test_g2b();
    set_req(1, 1'b1, 1'b1, 4'hB);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL g2b_req1_ready: got %b required 1", req1_ready); end
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL g2b_req0_ready: got %b required 0", req0_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL g2b_latency: got %0d required 5", lat); end
    n_vec++; if (res_data !== 4'hD) begin n_err++; $display("FAIL g2b_data: got %h required d", res_data); end
    n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL g2b_id: got %b required 1", res_id); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL g2b_done_busy: got %b required 0", busy); end
  endtask

  task automatic test_tie();
    apply_reset();
    set_req(0, 1'b1, 1'b0, 4'hF);
    set_req(1, 1'b1, 1'b0, 4'h0);
    res_ready = 1'b1;
    #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL tie_req0_ready: got %b required 1", req0_ready); end
    n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL tie_req1_ready: got %b required 0", req1_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL tie_first_latency: got %0d required 2", lat); end
    n_vec++; if (res_data !== 4'h8) begin n_err++; $display("FAIL tie_first_data: got %h required 8", res_data); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL tie_first_id: got %b required 0", res_id); end
    tick();
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL tie_second_ready: got %b required 1", req1_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'h0) begin n_err++; $display("FAIL tie_second_data: got %h required 0", res_data); end
    n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL tie_second_id: got %b required 1", res_id); end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Serve req0 alone so req1 is owed the next tie.
    res_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'h3);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'h2) begin n_err++; $display("FAIL b2b_solo_data: got %h required 2", res_data); end
    tick();
    set_req(0, 1'b1, 1'b1, 4'h6);
    set_req(1, 1'b1, 1'b1, 4'h9);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL b2b_tie_req1_ready: got %b required 1", req1_ready); end
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL b2b_tie_req0_ready: got %b required 0", req0_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL b2b_req1_latency: got %0d required 5", lat); end
    n_vec++; if (res_data !== 4'hE) begin n_err++; $display("FAIL b2b_req1_data: got %h required e", res_data); end
    n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL b2b_req1_id: got %b required 1", res_id); end
    tick();
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL b2b_req0_ready: got %b required 1", req0_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'h4) begin n_err++; $display("FAIL b2b_req0_data: got %h required 4", res_data); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL b2b_req0_id: got %b required 0", res_id); end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_stall();
    // last_gnt is 0 here, so req1 wins the tie and req0 is stalled.
    set_req(0, 1'b1, 1'b0, 4'h5);
    set_req(1, 1'b1, 1'b0, 4'hA);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL stall_req1_ready: got %b required 1", req1_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'hF) begin n_err++; $display("FAIL stall_data: got %h required f", res_data); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold_valid: cycle %0d got %b required 1", c, res_valid); end
      n_vec++; if (res_data !== 4'hF) begin n_err++; $display("FAIL stall_hold_data: cycle %0d got %h required f", c, res_data); end
      n_vec++; if (res_id !== 1'b1) begin n_err++; $display("FAIL stall_hold_id: cycle %0d got %b required 1", c, res_id); end
      n_vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: cycle %0d got %b%b required 00", c, req0_ready, req1_ready); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stall_busy: cycle %0d got %b required 1", c, busy); end
    end
    res_ready = 1'b1;
    tick();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stall_release_valid: got %b required 0", res_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_release_busy: got %b required 0", busy); end
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL stall_req0_next: got %b required 1", req0_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'h7) begin n_err++; $display("FAIL stall_req0_data: got %h required 7", res_data); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL stall_req0_id: got %b required 0", res_id); end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_g2b();
    set_req(1, 1'b1, 1'b1, 4'hB);
    #1;
    n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL rmid_req1_ready: got %b required 1", req1_ready); end
    tick();
    set_req(1, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b required 0", busy); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b required 0", res_valid); end
    n_vec++; if (res_data !== 4'h0) begin n_err++; $display("FAIL rmid_data: got %h required 0", res_data); end
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 4'h8);
    set_req(1, 1'b1, 1'b1, 4'hB);
    #1;
    n_vec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_err++; $display("FAIL rmid_tie: got %b%b required 10", req0_ready, req1_ready); end
    // Withdraw both before any edge; nothing must be reported.
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    repeat (8) tick();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_no_result: got valid %b busy %b required 0 0", res_valid, busy); end
  endtask

`ifdef GRAY_CONV_PARITY_EN
  task automatic test_parity();
    apply_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'hD);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'hB) begin n_err++; $display("FAIL par13_data: got %h required b", res_data); end
    n_vec++; if (res_parity !== 1'b1) begin n_err++; $display("FAIL par13_parity: got %b required 1", res_parity); end
    tick();
    set_req(0, 1'b1, 1'b0, 4'h8);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    wait_result(lat);
    n_vec++; if (res_data !== 4'hC) begin n_err++; $display("FAIL par8_data: got %h required c", res_data); end
    n_vec++; if (res_parity !== 1'b0) begin n_err++; $display("FAIL par8_parity: got %b required 0", res_parity); end
    tick();
    res_ready = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_b2g();
    test_g2b();
    test_tie();
    test_back_to_back();
    test_stall();
    test_reset_mid_g2b();
`ifdef GRAY_CONV_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
